// File: rtl/bottleneck_pkg.sv
// Shared definitions for the Bottleneck target: FSM states, beat sizes and lane helpers.
package bottleneck_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDATA = 2'd1,
        ACK   = 2'd2
    } stateT;

    localparam logic [1:0] SIZ_BYTE = 2'b00;
    localparam logic [1:0] SIZ_HALF = 2'b01;

    // Any size other than SIZ_BYTE is serviced as a halfword; adrLow[0] is ignored then.
    function automatic logic [7:0] laneSel(input logic [1:0] siz, input logic [2:0] adrLow);
        if (siz == SIZ_BYTE) return 8'b0000_0001 << adrLow;
        return 8'b0000_0011 << {adrLow[2:1], 1'b0};
    endfunction

    function automatic logic [63:0] replicate(input logic [1:0] siz, input logic [15:0] dat);
        if (siz == SIZ_BYTE) return {8{dat[7:0]}};
        return {4{dat}};
    endfunction

endpackage

// File: rtl/bottleneck_target_if.sv
// Narrow 8/16-bit beat bus between the Bottleneck bridge (master) and its target (slave).
interface bottleneck_target_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [1:0]            siz;
    logic                  sgn;
    logic [ADDR_WIDTH-1:0] adr;
    logic [15:0]           wrDat;
    logic [15:0]           rdDat;
    logic                  ack;

    modport master (
        output cyc, stb, we, siz, sgn, adr, wrDat,
        input  rdDat, ack
    );

    modport slave (
        input  cyc, stb, we, siz, sgn, adr, wrDat,
        output rdDat, ack
    );
endinterface

// File: rtl/bottleneck_lane_mux.sv
// Steers one 16-bit lane out of a 64-bit doubleword and applies byte zero/sign extension.
module bottleneck_lane_mux
    import bottleneck_pkg::*;
(
    input  logic [63:0] line,
    input  logic [2:0]  adrLow,
    input  logic [1:0]  siz,
    input  logic        sgn,
    output logic [15:0] dat
);
    logic [15:0] half;
    logic [7:0]  byteVal;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        half    = line[15:0];
        byteVal = 8'h00;
        dat     = 16'h0000;
        case (adrLow[2:1])
            2'd0: half = line[15:0];
            2'd1: half = line[31:16];
            2'd2: half = line[47:32];
            2'd3: half = line[63:48];
            default: half = line[15:0];
        endcase
        byteVal = adrLow[0] ? half[15:8] : half[7:0];
        if (siz == SIZ_BYTE) dat = {{8{sgn & byteVal[7]}}, byteVal};
        else                 dat = half;
    end
endmodule

// File: rtl/bottleneck_target.sv
// 16-bit responder serving 8/16-bit beats from a 64-bit byte-enabled RAM.
// Optional write-through line buffer enabled by defining BOTTLENECK_TARGET_LINEBUF_EN.
module bottleneck_target
    import bottleneck_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bottleneck_target_if.slave    bus,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [7:0]            mem_sel_o,
    output logic [ADDR_WIDTH-4:0] mem_adr_o,
    output logic [63:0]           mem_dat_o,
    input  logic [63:0]           mem_dat_i
);
    stateT       state, nextState;
    logic        req, capture, hit, ack;
    logic [7:0]  sel;
    logic [2:0]  adrLowQ;
    logic [1:0]  sizQ;
    logic        sgnQ;
    logic [15:0] datQ, laneDat;
    logic [63:0] muxLine;
    logic [2:0]  muxAdr;
    logic [1:0]  muxSiz;
    logic        muxSgn;

    assign req       = bus.cyc & bus.stb;
    assign sel       = laneSel(bus.siz, bus.adr[2:0]);
    assign mem_adr_o = bus.adr[ADDR_WIDTH-1:3];
    assign mem_dat_o = replicate(bus.siz, bus.wrDat);
    assign mem_sel_o = mem_en_o ? sel : 8'h00;
    assign bus.rdDat = datQ;
    assign bus.ack   = ack;

`ifdef BOTTLENECK_TARGET_LINEBUF_EN
    logic [63:0]           lineBuf;
    logic [ADDR_WIDTH-4:0] lineTag, tagQ;
    logic                  lineValid;

    assign hit = lineValid && (lineTag == mem_adr_o);

    // Hits are steered straight out of the buffer using the live request fields.
    always_comb begin
        muxLine = lineBuf;
        muxAdr  = bus.adr[2:0];
        muxSiz  = bus.siz;
        muxSgn  = bus.sgn;
        if (state == RDATA) begin
            muxLine = mem_dat_i;
            muxAdr  = adrLowQ;
            muxSiz  = sizQ;
            muxSgn  = sgnQ;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) lineValid <= 1'b0;
        else if (state == RDATA) lineValid <= 1'b1;
    end

    // NOTE: buffer data and tag carry no reset; lineValid alone decides whether they mean anything.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && req) tagQ <= mem_adr_o;
        if (!reset_i && state == RDATA) begin
            lineBuf <= mem_dat_i;
            lineTag <= tagQ;
        end else if (mem_we_o && hit) begin
            for (int i = 0; i < 8; i++)
                if (sel[i]) lineBuf[8*i +: 8] <= mem_dat_o[8*i +: 8];
        end
    end
`else
    assign hit     = 1'b0;
    assign muxLine = mem_dat_i;
    assign muxAdr  = adrLowQ;
    assign muxSiz  = sizQ;
    assign muxSgn  = sgnQ;
`endif

    bottleneck_lane_mux u_laneMux (
        .line   (muxLine),
        .adrLow (muxAdr),
        .siz    (muxSiz),
        .sgn    (muxSgn),
        .dat    (laneDat)
    );

    always_comb begin
        nextState = state;
        mem_en_o  = 1'b0;
        mem_we_o  = 1'b0;
        ack       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (bus.we) begin
                    mem_en_o  = 1'b1;
                    mem_we_o  = 1'b1;
                    nextState = ACK;
                end else if (hit) begin
                    capture   = 1'b1;
                    nextState = ACK;
                end else begin
                    mem_en_o  = 1'b1;
                    nextState = RDATA;
                end
            end
            RDATA: begin
                capture   = req;
                nextState = req ? ACK : IDLE;
            end
            ACK: begin
                ack       = req;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Reset overrides any request seen in the same cycle.
        if (reset_i) begin
            mem_en_o = 1'b0;
            mem_we_o = 1'b0;
            ack      = 1'b0;
            capture  = 1'b0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            datQ  <= 16'h0000;
        end else begin
            state <= nextState;
            if (capture) datQ <= laneDat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == IDLE && req) begin
            adrLowQ <= bus.adr[2:0];
            sizQ    <= bus.siz;
            sgnQ    <= bus.sgn;
        end
    end
endmodule

// File: tb/tb_bottleneck_target.sv
// Self-checking bench for bottleneck_target: byte-array reference model, 64-bit RAM model,
// directed scenarios plus randomized beats; runs with or without BOTTLENECK_TARGET_LINEBUF_EN.
module tb_bottleneck_target;
    import bottleneck_pkg::*;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          memEn, memWe;
    logic [7:0]    memSel;
    logic [AW-4:0] memAdr;
    logic [63:0]   memDatW;
    logic [63:0]   memDatR = '0;

    bottleneck_target_if #(.ADDR_WIDTH(AW)) bus ();

    bottleneck_target #(.ADDR_WIDTH(AW)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .bus       (bus),
        .mem_en_o  (memEn),
        .mem_we_o  (memWe),
        .mem_sel_o (memSel),
        .mem_adr_o (memAdr),
        .mem_dat_o (memDatW),
        .mem_dat_i (memDatR)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after a read enable.
    bit [63:0] ram [0:15];
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) begin
                for (int i = 0; i < 8; i++)
                    if (memSel[i]) ram[memAdr[3:0]][8*i +: 8] <= memDatW[8*i +: 8];
            end else begin
                memDatR <= ram[memAdr[3:0]];
            end
        end
    end

    // Reference view: plain little-endian byte memory plus which doubleword the buffer holds.
    byte unsigned refMem [0:127];
    bit  tbValid = 1'b0;
    int  tbTag   = 0;
    bit  prevHold = 1'b0;
    int  checks   = 0;
    int  failures = 0;

    function automatic logic [15:0] expRead(input int adr, input logic [1:0] siz, input logic sgn);
        int          a;
        logic [7:0]  b;
        if (siz == SIZ_BYTE) begin
            b = refMem[adr];
            return (sgn && b[7]) ? {8'hFF, b} : {8'h00, b};
        end
        a = adr & ~1;
        return {refMem[a+1], refMem[a]};
    endfunction

    task automatic doBeat(input logic we, input logic [1:0] siz, input logic sgn, input int adr,
                          input logic [15:0] wdat, input bit hold);
        bit          isHit, follow;
        int          expLat, lat;
        logic        expEn;
        logic [7:0]  expSel;
        logic [63:0] expDat;
        logic [15:0] want;
        follow = prevHold;
        isHit  = 1'b0;
`ifdef BOTTLENECK_TARGET_LINEBUF_EN
        isHit = !we && tbValid && (tbTag == adr / 8);
`endif
        expEn  = !isHit;
        expLat = (we || isHit) ? 1 : 2;
        if (follow) expLat = expLat + 1;
        expSel = (siz == SIZ_BYTE) ? 8'(1 << (adr % 8)) : 8'(3 << ((adr % 8) & 6));
        expDat = (siz == SIZ_BYTE) ? {8{wdat[7:0]}} : {4{wdat}};
        want   = expRead(adr, siz, sgn);

        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.siz = siz; bus.sgn = sgn;
        bus.adr = AW'(adr); bus.wrDat = wdat;
        if (!follow) begin
            #1;
            checks++;
            if (memEn !== expEn || memWe !== (we & expEn)) begin
                failures++;
                $display("FAIL mem_enable adr=%0h got en=%b we=%b want en=%b we=%b", adr, memEn, memWe, expEn, we & expEn);
            end
            if (expEn) begin
                checks++;
                if (memSel !== expSel || memAdr !== (AW-3)'(adr / 8)) begin
                    failures++;
                    $display("FAIL mem_sel_adr adr=%0h got sel=%h dw=%0h want sel=%h dw=%0h", adr, memSel, memAdr, expSel, adr / 8);
                end
            end
            if (we) begin
                checks++;
                if (memDatW !== expDat) begin
                    failures++;
                    $display("FAIL mem_wdata adr=%0h got %h want %h", adr, memDatW, expDat);
                end
            end
        end

        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus.ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != expLat) begin
            failures++;
            $display("FAIL ack_latency adr=%0h we=%b got %0d want %0d (0 = no ack)", adr, we, lat, expLat);
        end
        if (!we && lat != 0) begin
            checks++;
            if (bus.rdDat !== want) begin
                failures++;
                $display("FAIL read_data adr=%0h siz=%b sgn=%b got %h want %h", adr, siz, sgn, bus.rdDat, want);
            end
        end

        if (we) begin
            if (siz == SIZ_BYTE) refMem[adr] = wdat[7:0];
            else begin
                refMem[adr & ~1]       = wdat[7:0];
                refMem[(adr & ~1) + 1] = wdat[15:8];
            end
        end else if (!isHit) begin
            tbValid = 1'b1;
            tbTag   = adr / 8;
        end
        prevHold = hold;
        if (!hold) begin
            @(negedge clk);
            bus.cyc = 1'b0; bus.stb = 1'b0;
        end
    endtask

    task automatic test_reset;
        bit bad;
        reset = 1'b1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.siz = SIZ_HALF; bus.sgn = 1'b0;
        bus.adr = 24'h000006; bus.wrDat = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.ack !== 1'b0 || memEn !== 1'b0 || memWe !== 1'b0 || memSel !== 8'h00 || bus.rdDat !== 16'h0000) begin
                failures++;
                $display("FAIL reset_outputs got ack=%b en=%b we=%b sel=%h dat=%h want all zero", bus.ack, memEn, memWe, memSel, bus.rdDat);
            end
        end
        // Release reset with a read pending, then reassert reset while it sits in RDATA.
        @(negedge clk);
        reset = 1'b0; bus.we = 1'b0; bus.adr = 24'h000020;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        @(posedge clk); #1;
        if (bus.ack !== 1'b0) bad = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.ack !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || bus.rdDat !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_read got ack_seen=%b dat=%h want ack_seen=0 dat=0000", bad, bus.rdDat);
        end
        tbValid = 1'b0;
    endtask

    task automatic test_spec_vectors;
        doBeat(1'b1, SIZ_HALF, 1'b0, 6, 16'hBEEF, 1'b0);
        doBeat(1'b1, SIZ_HALF, 1'b0, 0, 16'h0000, 1'b0);
        doBeat(1'b1, SIZ_HALF, 1'b0, 2, 16'h0000, 1'b0);
        doBeat(1'b1, SIZ_HALF, 1'b0, 4, 16'h8000, 1'b0);
        doBeat(1'b1, SIZ_HALF, 1'b0, 6, 16'h0000, 1'b0);
        doBeat(1'b0, SIZ_BYTE, 1'b1, 5, 16'h0000, 1'b0);
        doBeat(1'b0, SIZ_BYTE, 1'b0, 5, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back;
        doBeat(1'b1, SIZ_HALF, 1'b0, 0, 16'h4444, 1'b0);
        doBeat(1'b1, SIZ_HALF, 1'b0, 2, 16'h3333, 1'b0);
        doBeat(1'b1, SIZ_HALF, 1'b0, 4, 16'h2222, 1'b0);
        doBeat(1'b1, SIZ_HALF, 1'b0, 6, 16'h1111, 1'b0);
        doBeat(1'b0, SIZ_HALF, 1'b0, 0, 16'h0000, 1'b1);
        doBeat(1'b0, SIZ_HALF, 1'b0, 2, 16'h0000, 1'b1);
        doBeat(1'b0, SIZ_HALF, 1'b0, 4, 16'h0000, 1'b1);
        doBeat(1'b0, SIZ_HALF, 1'b0, 6, 16'h0000, 1'b0);
    endtask

    task automatic test_cyc_drop;
        bit seen;
        int l2;
        l2 = (tbValid && tbTag == 8) ? 'h48 : 'h40;
        doBeat(1'b1, SIZ_HALF, 1'b0, l2, 16'hC0DE, 1'b0);
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.siz = SIZ_HALF; bus.sgn = 1'b0;
        bus.adr = 24'h000018;
        @(posedge clk);
        @(negedge clk);
        bus.cyc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL cyc_drop_ack got ack_seen=1 want 0");
        end
        bus.stb = 1'b0;
        doBeat(1'b0, SIZ_HALF, 1'b0, l2, 16'h0000, 1'b0);
    endtask

    task automatic test_linebuf;
        doBeat(1'b0, SIZ_HALF, 1'b0, 'h10, 16'h0000, 1'b0);
        doBeat(1'b0, SIZ_HALF, 1'b0, 'h12, 16'h0000, 1'b0);
        doBeat(1'b1, SIZ_BYTE, 1'b0, 'h12, 16'hA55A, 1'b0);
        doBeat(1'b0, SIZ_BYTE, 1'b0, 'h12, 16'h0000, 1'b0);
        doBeat(1'b0, SIZ_HALF, 1'b0, 'h12, 16'h0000, 1'b0);
    endtask

    task automatic test_random;
        int          n;
        logic        we;
        logic [1:0]  siz;
        bit          hold;
        n = 60;
        for (int i = 0; i < n; i++) begin
            we   = 1'($urandom_range(0, 1));
            siz  = 2'($urandom_range(0, 3));
            hold = (i != n - 1) && ($urandom_range(0, 3) == 0);
            doBeat(we, siz, 1'($urandom_range(0, 1)), $urandom_range(0, 127),
                   16'($urandom), hold);
        end
    endtask

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.siz = SIZ_BYTE; bus.sgn = 1'b0;
        bus.adr = '0; bus.wrDat = '0;
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_cyc_drop();
        test_linebuf();
        test_random();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
